// File: rtl/axis_vip_pkg.sv
// Shared AXI-Stream helper types: lane-index sizing and the unpacker state enum.
package axis_vip_pkg;

  localparam int AXIS_WORD_W         = 8;
  localparam int AXIS_BUS_W          = 32;
  localparam int AXIS_WORDS_PER_BEAT = AXIS_BUS_W / AXIS_WORD_W;

  // A single-lane bus still needs a 1-bit pointer so the index type never collapses.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AXIS_LANE_W = (AXIS_WORDS_PER_BEAT > 1) ? $clog2(AXIS_WORDS_PER_BEAT) : 1;

  typedef logic [AXIS_LANE_W-1:0] lane_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/axis_lane_select.sv
// Combinational lane walker: next set lane after ptr and whether ptr is the final set lane.
// AXIS_UNPACK_SPARSE_KEEP_EN selects the sparse (holes allowed) search over keep.
module axis_lane_select
  import axis_vip_pkg::*;
#(
  parameter int N  = AXIS_WORDS_PER_BEAT,
  parameter int LW = lane_bits(N)
) (
  input  logic [N-1:0]  keep,
  input  logic [LW-1:0] ptr,
  output logic [LW-1:0] next_lane,
  output logic          is_final
);

`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
  // Walk downwards so the lowest set lane above ptr is the one that sticks.
  always_comb begin
    next_lane = '0;
    is_final  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (keep[i] && (i > int'(ptr))) begin
        next_lane = LW'(i);
        is_final  = 1'b0;
      end
    end
  end
`else
  int cnt;

  always_comb begin
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cnt += int'(keep[i]);
    end
    next_lane = ptr + LW'(1);
    is_final  = (int'(ptr) == cnt - 1);
  end
`endif

endmodule

// File: rtl/axis_beat_unpacker.sv
// AXI-Stream width downconverter: one BUS_W beat in, WORDS_PER_BEAT WORD_W words out.
// Define AXIS_UNPACK_SPARSE_KEEP_EN to accept keep masks with holes.
module axis_beat_unpacker
  import axis_vip_pkg::*;
#(
  parameter  int WORD_W         = AXIS_WORD_W,
  parameter  int BUS_W          = AXIS_BUS_W,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  s_data,
  input  logic [WORDS_PER_BEAT-1:0]              s_keep,
  input  logic                                   s_last,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [WORD_W-1:0]                      m_data,
  output logic                                   m_last,
  output logic [31:0]                            pkt_count,
  output logic                                   err_empty_last
);

  localparam int LANE_W = lane_bits(WORDS_PER_BEAT);

  state_e                                state_q, state_d;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] buf_data_q, buf_data_d;
  logic [WORDS_PER_BEAT-1:0]             buf_keep_q, buf_keep_d;
  logic                                  buf_last_q, buf_last_d;
  logic [LANE_W-1:0]                     ptr_q, ptr_d;
  logic [31:0]                           pkt_count_q, pkt_count_d;
  logic                                  err_q, err_d;

  logic [LANE_W-1:0] next_lane;
  logic [LANE_W-1:0] first_lane;
  logic              is_final;
  logic              m_hs;
  logic              s_hs;

  axis_lane_select #(
    .N  (WORDS_PER_BEAT),
    .LW (LANE_W)
  ) u_lane_select (
    .keep      (buf_keep_q),
    .ptr       (ptr_q),
    .next_lane (next_lane),
    .is_final  (is_final)
  );

`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
  always_comb begin
    first_lane = '0;
    for (int i = WORDS_PER_BEAT - 1; i >= 0; i--) begin
      if (s_keep[i]) first_lane = LANE_W'(i);
    end
  end
`else
  assign first_lane = '0;
`endif

  assign m_valid        = (state_q == HOLD);
  assign m_data         = buf_data_q[ptr_q];
  assign m_last         = m_valid & buf_last_q & is_final;
  assign pkt_count      = pkt_count_q;
  assign err_empty_last = err_q;

  // Accepting on the final-word drain is what keeps back-to-back beats bubble-free.
  assign m_hs    = m_valid & m_ready;
  assign s_ready = (state_q == EMPTY) | (m_hs & is_final);
  assign s_hs    = s_valid & s_ready;

  // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_keep_d  = buf_keep_q;
    buf_last_d  = buf_last_q;
    ptr_d       = ptr_q;
    pkt_count_d = pkt_count_q;
    err_d       = 1'b0;

    if (m_hs) begin
      if (is_final) state_d = EMPTY;
      else          ptr_d   = next_lane;
      if (m_last) pkt_count_d = pkt_count_q + 32'd1;
    end

    if (s_hs) begin
      if (s_keep != '0) begin
        buf_data_d = s_data;
        buf_keep_d = s_keep;
        buf_last_d = s_last;
        ptr_d      = first_lane;
        state_d    = HOLD;
      end else if (s_last) begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: the beat buffer is reset too, so m_data reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      buf_data_q  <= '0;
      buf_keep_q  <= '0;
      buf_last_q  <= 1'b0;
      ptr_q       <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_keep_q  <= buf_keep_d;
      buf_last_q  <= buf_last_d;
      ptr_q       <= ptr_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

`ifndef AXIS_UNPACK_SPARSE_KEEP_EN
`ifndef SYNTHESIS
  a_keep_contiguous: assert property (@(posedge clk) disable iff (!rstn)
    (s_valid && s_ready) |-> ((s_keep & (s_keep + WORDS_PER_BEAT'(1))) == '0))
    else $error("axis_beat_unpacker: non-contiguous s_keep %b", s_keep);
`endif
`endif

endmodule
